// File: rtl/per2axi_req_pipe.sv
// per2axi_req_pipe
//
// Request path of the peripheral-to-AXI bridge. A 32-bit peripheral request
// is granted into a single-entry slot and issued from there as an AXI4 read
// (AR) or write (AW + W, optionally with ATOP or exclusive lock). Write data
// and strobes are steered onto the 32-bit lane selected by the address.
// Outstanding reads and writes are bounded by per-direction credit counters
// that the response path returns through b_done_i / r_done_i.
//
// Ports
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   per_slave_*                     peripheral request side (req/gnt, add,
//                                   we: 1 = read, atop, wdata, be, one-hot id)
//   axi_master_aw_* / ar_* / w_*    AXI4 request channels; unused attributes
//                                   are tied to 0 (burst FIXED, len 0)
//   b_done_i, r_done_i              one write / read response retired
//   trans_req_o/_id_o/_add_o        pulse with each AR handshake
//   atop_req_o/_id_o/_add_o         pulse with the AW handshake of a
//                                   load-type ATOP
//   dbg_state_o                     slot state (0 EMPTY, 1 RD, 2 WR)
//   dbg_wr_cnt_o, dbg_rd_cnt_o      credit counters
//
// Handshake rule for every AXI channel: valid comes only from flops, never
// from ready; once valid is high it stays high with a stable payload until
// the cycle in which its ready is sampled high; that cycle is the handshake.

module per2axi_req_pipe #(
  parameter int unsigned PER_ADDR_WIDTH  = 32,
  parameter int unsigned PER_ID_WIDTH    = 5,
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned AXI_DATA_WIDTH  = 64,
  parameter int unsigned AXI_ID_WIDTH    = 3,
  parameter int unsigned AXI_USER_WIDTH  = 6,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  // peripheral request
  input  logic                                       per_slave_req_i,
  output logic                                       per_slave_gnt_o,
  input  logic [PER_ADDR_WIDTH-1:0]                  per_slave_add_i,
  input  logic                                       per_slave_we_i,
  input  logic [5:0]                                 per_slave_atop_i,
  input  logic [31:0]                                per_slave_wdata_i,
  input  logic [3:0]                                 per_slave_be_i,
  input  logic [PER_ID_WIDTH-1:0]                    per_slave_id_i,
  // AW channel
  output logic                                       axi_master_aw_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]                  axi_master_aw_addr_o,
  output logic [2:0]                                 axi_master_aw_size_o,
  output logic                                       axi_master_aw_lock_o,
  output logic [5:0]                                 axi_master_aw_atop_o,
  output logic [AXI_ID_WIDTH-1:0]                    axi_master_aw_id_o,
  input  logic                                       axi_master_aw_ready_i,
  output logic [2:0]                                 axi_master_aw_prot_o,
  output logic [3:0]                                 axi_master_aw_region_o,
  output logic [7:0]                                 axi_master_aw_len_o,
  output logic [3:0]                                 axi_master_aw_cache_o,
  output logic [3:0]                                 axi_master_aw_qos_o,
  output logic [AXI_USER_WIDTH-1:0]                  axi_master_aw_user_o,
  output logic [1:0]                                 axi_master_aw_burst_o,
  // AR channel
  output logic                                       axi_master_ar_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]                  axi_master_ar_addr_o,
  output logic [2:0]                                 axi_master_ar_size_o,
  output logic                                       axi_master_ar_lock_o,
  output logic [AXI_ID_WIDTH-1:0]                    axi_master_ar_id_o,
  input  logic                                       axi_master_ar_ready_i,
  output logic [2:0]                                 axi_master_ar_prot_o,
  output logic [3:0]                                 axi_master_ar_region_o,
  output logic [7:0]                                 axi_master_ar_len_o,
  output logic [3:0]                                 axi_master_ar_cache_o,
  output logic [3:0]                                 axi_master_ar_qos_o,
  output logic [AXI_USER_WIDTH-1:0]                  axi_master_ar_user_o,
  output logic [1:0]                                 axi_master_ar_burst_o,
  // W channel
  output logic                                       axi_master_w_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]                  axi_master_w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0]                axi_master_w_strb_o,
  output logic                                       axi_master_w_last_o,
  output logic [AXI_USER_WIDTH-1:0]                  axi_master_w_user_o,
  input  logic                                       axi_master_w_ready_i,
  // response retirement
  input  logic                                       b_done_i,
  input  logic                                       r_done_i,
  // transaction notifications
  output logic                                       trans_req_o,
  output logic [AXI_ID_WIDTH-1:0]                    trans_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]                  trans_add_o,
  output logic                                       atop_req_o,
  output logic [AXI_ID_WIDTH-1:0]                    atop_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]                  atop_add_o,
  // debug
  output logic [1:0]                                 dbg_state_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       dbg_wr_cnt_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       dbg_rd_cnt_o
);

  localparam int unsigned NUM_LANES = AXI_DATA_WIDTH / 32;
  localparam int unsigned LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned STRB_W    = AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_RD    = 2'd1,
    SLOT_WR    = 2'd2
  } slot_e;

  // ---------------------------------------------------------------------
  // Request decode (purely combinational on the peripheral inputs)
  // ---------------------------------------------------------------------
  logic                      is_lr, is_sc, invert_data;
  logic [5:0]                atop_map;
  logic                      req_is_read, req_lock, req_load;
  logic [5:0]                req_atop;
  logic [2:0]                req_size;
  logic [AXI_ID_WIDTH-1:0]   req_id;
  logic [31:0]               wdata_eff;
  logic [LANE_W-1:0]         lane;
  logic [AXI_DATA_WIDTH-1:0] req_data;
  logic [STRB_W-1:0]         req_strb;

  if (NUM_LANES > 1) begin : g_lane
    assign lane = per_slave_add_i[LANE_W+1:2];
  end else begin : g_no_lane
    assign lane = '0;
  end

  always_comb begin
    is_lr       = per_slave_atop_i[5] && (per_slave_atop_i[4:0] == 5'b00010);
    is_sc       = per_slave_atop_i[5] && (per_slave_atop_i[4:0] == 5'b00011);
    atop_map    = 6'b000000;
    invert_data = 1'b0;
    if (per_slave_atop_i[5]) begin
      case (per_slave_atop_i[4:0])
        5'b00001: atop_map = 6'b110000;  // SWAP
        5'b00000: atop_map = 6'b100000;  // ADD
        5'b00100: atop_map = 6'b100010;  // XOR -> EOR
        5'b01100: begin                  // AND -> CLR of the inverted operand
          atop_map    = 6'b100001;
          invert_data = 1'b1;
        end
        5'b01000: atop_map = 6'b100011;  // OR -> SET
        5'b10000: atop_map = 6'b100101;  // MIN -> SMIN
        5'b10100: atop_map = 6'b100100;  // MAX -> SMAX
        5'b11000: atop_map = 6'b100111;  // MINU -> UMIN
        5'b11100: atop_map = 6'b100110;  // MAXU -> UMAX
        default:  atop_map = 6'b000000;  // LR/SC and unknown: no ATOP
      endcase
    end

    req_is_read = per_slave_we_i || is_lr;
    // A read never carries ATOP; the lock bit tracks LR on AR, SC on AW.
    req_atop    = req_is_read ? 6'b000000 : atop_map;
    req_lock    = req_is_read ? is_lr : is_sc;
    // Everything except store-type ATOPs (01xxxx) returns R data as well.
    req_load    = (req_atop != 6'b000000) && (req_atop[5:4] != 2'b01);

    if (per_slave_be_i == (4'b0001 << per_slave_add_i[1:0])) begin
      req_size = 3'd0;
    end else if (((per_slave_add_i[1:0] == 2'd0) && (per_slave_be_i == 4'b0011)) ||
                 ((per_slave_add_i[1:0] == 2'd2) && (per_slave_be_i == 4'b1100))) begin
      req_size = 3'd1;
    end else begin
      req_size = 3'd2;
    end

    // Highest set bit of the one-hot ID wins; later iterations override.
    req_id = '0;
    for (int i = 0; i < int'(PER_ID_WIDTH); i++) begin
      if (per_slave_id_i[i]) req_id = AXI_ID_WIDTH'(i);
    end

    wdata_eff = invert_data ? ~per_slave_wdata_i : per_slave_wdata_i;
    req_data  = '0;
    req_strb  = '0;
    for (int l = 0; l < int'(NUM_LANES); l++) begin
      if (lane == LANE_W'(l)) begin
        req_data[32*l +: 32] = wdata_eff;
        req_strb[4*l +: 4]   = per_slave_be_i;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Slot FSM: state register
  // ---------------------------------------------------------------------
  slot_e state_q, state_d;
  logic  aw_sent_q, aw_sent_d;
  logic  w_sent_q, w_sent_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= SLOT_EMPTY;
      aw_sent_q <= 1'b0;
      w_sent_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_sent_q <= aw_sent_d;
      w_sent_q  <= w_sent_d;
    end
  end

  // ---------------------------------------------------------------------
  // Slot FSM: output decode (valids depend only on flops)
  // ---------------------------------------------------------------------
  logic ar_valid, aw_valid, w_valid;

  always_comb begin
    ar_valid = (state_q == SLOT_RD);
    aw_valid = (state_q == SLOT_WR) && !aw_sent_q;
    w_valid  = (state_q == SLOT_WR) && !w_sent_q;
  end

  logic ar_hs, aw_hs, w_hs, wr_done, slot_free;
  logic wr_dec, rd_dec, wr_ok, rd_ok, credit_ok, accept;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

  assign ar_hs     = ar_valid && axi_master_ar_ready_i;
  assign aw_hs     = aw_valid && axi_master_aw_ready_i;
  assign w_hs      = w_valid  && axi_master_w_ready_i;
  // The write leaves the slot once both halves have gone, in either order.
  assign wr_done   = (aw_sent_q || aw_hs) && (w_sent_q || w_hs);
  assign slot_free = (state_q == SLOT_EMPTY) ||
                     ((state_q == SLOT_RD) && ar_hs) ||
                     ((state_q == SLOT_WR) && wr_done);

  // A credit returned this cycle can be reused by a grant in the same cycle.
  assign wr_dec    = b_done_i && (wr_cnt_q != '0);
  assign rd_dec    = r_done_i && (rd_cnt_q != '0);
  assign wr_ok     = (wr_cnt_q - CNT_W'(wr_dec)) < CNT_W'(MAX_OUTSTANDING);
  assign rd_ok     = (rd_cnt_q - CNT_W'(rd_dec)) < CNT_W'(MAX_OUTSTANDING);
  assign credit_ok = req_is_read ? rd_ok : (wr_ok && (!req_load || rd_ok));
  assign accept    = per_slave_req_i && slot_free && credit_ok;

  // ---------------------------------------------------------------------
  // Slot FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    aw_sent_d = aw_sent_q;
    w_sent_d  = w_sent_q;
    case (state_q)
      SLOT_RD: begin
        if (ar_hs) state_d = SLOT_EMPTY;
      end
      SLOT_WR: begin
        if (aw_hs) aw_sent_d = 1'b1;
        if (w_hs)  w_sent_d  = 1'b1;
        if (wr_done) begin
          state_d   = SLOT_EMPTY;
          aw_sent_d = 1'b0;
          w_sent_d  = 1'b0;
        end
      end
      default: state_d = state_q;
    endcase
    // A grant in the freeing cycle refills the slot immediately.
    if (accept) begin
      state_d   = req_is_read ? SLOT_RD : SLOT_WR;
      aw_sent_d = 1'b0;
      w_sent_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Captured payload
  // ---------------------------------------------------------------------
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [2:0]                size_q, size_d;
  logic [5:0]                atop_q, atop_d;
  logic                      lock_q, lock_d;
  logic                      load_q, load_d;
  logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic [STRB_W-1:0]         strb_q, strb_d;

  always_comb begin
    addr_d = addr_q;
    id_d   = id_q;
    size_d = size_q;
    atop_d = atop_q;
    lock_d = lock_q;
    load_d = load_q;
    data_d = data_q;
    strb_d = strb_q;
    if (accept) begin
      addr_d = AXI_ADDR_WIDTH'(per_slave_add_i);
      id_d   = req_id;
      size_d = req_size;
      atop_d = req_atop;
      lock_d = req_lock;
      load_d = req_load;
      data_d = req_data;
      strb_d = req_strb;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      id_q   <= '0;
      size_q <= '0;
      atop_q <= '0;
      lock_q <= 1'b0;
      load_q <= 1'b0;
      data_q <= '0;
      strb_q <= '0;
    end else begin
      addr_q <= addr_d;
      id_q   <= id_d;
      size_q <= size_d;
      atop_q <= atop_d;
      lock_q <= lock_d;
      load_q <= load_d;
      data_q <= data_d;
      strb_q <= strb_d;
    end
  end

  // ---------------------------------------------------------------------
  // Credit counters
  // ---------------------------------------------------------------------
  logic wr_inc, rd_inc;

  always_comb begin
    wr_inc   = accept && !req_is_read;
    rd_inc   = accept && (req_is_read || req_load);
    wr_cnt_d = wr_cnt_q + CNT_W'(wr_inc) - CNT_W'(wr_dec);
    rd_cnt_d = rd_cnt_q + CNT_W'(rd_inc) - CNT_W'(rd_dec);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Output wiring
  // ---------------------------------------------------------------------
  assign per_slave_gnt_o        = accept;

  assign axi_master_aw_valid_o  = aw_valid;
  assign axi_master_aw_addr_o   = addr_q;
  assign axi_master_aw_size_o   = size_q;
  assign axi_master_aw_lock_o   = lock_q;
  assign axi_master_aw_atop_o   = atop_q;
  assign axi_master_aw_id_o     = id_q;
  assign axi_master_aw_prot_o   = '0;
  assign axi_master_aw_region_o = '0;
  assign axi_master_aw_len_o    = '0;
  assign axi_master_aw_cache_o  = '0;
  assign axi_master_aw_qos_o    = '0;
  assign axi_master_aw_user_o   = '0;
  assign axi_master_aw_burst_o  = '0;

  assign axi_master_ar_valid_o  = ar_valid;
  assign axi_master_ar_addr_o   = addr_q;
  assign axi_master_ar_size_o   = size_q;
  assign axi_master_ar_lock_o   = lock_q;
  assign axi_master_ar_id_o     = id_q;
  assign axi_master_ar_prot_o   = '0;
  assign axi_master_ar_region_o = '0;
  assign axi_master_ar_len_o    = '0;
  assign axi_master_ar_cache_o  = '0;
  assign axi_master_ar_qos_o    = '0;
  assign axi_master_ar_user_o   = '0;
  assign axi_master_ar_burst_o  = '0;

  assign axi_master_w_valid_o   = w_valid;
  assign axi_master_w_data_o    = data_q;
  assign axi_master_w_strb_o    = strb_q;
  assign axi_master_w_last_o    = w_valid;
  assign axi_master_w_user_o    = '0;

  assign trans_req_o            = ar_hs;
  assign trans_id_o             = id_q;
  assign trans_add_o            = addr_q;
  assign atop_req_o             = aw_hs && load_q;
  assign atop_id_o              = id_q;
  assign atop_add_o             = addr_q;

  assign dbg_state_o            = state_q;
  assign dbg_wr_cnt_o           = wr_cnt_q;
  assign dbg_rd_cnt_o           = rd_cnt_q;

  // ---------------------------------------------------------------------
  // Simulation-only checks
  // ---------------------------------------------------------------------
  a_no_wr_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(b_done_i && (wr_cnt_q == '0)));
  a_no_rd_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(r_done_i && (rd_cnt_q == '0)));
  a_ar_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (ar_valid && !axi_master_ar_ready_i) |=> ar_valid);
  a_aw_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (aw_valid && !axi_master_aw_ready_i) |=> aw_valid);
  a_w_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_valid && !axi_master_w_ready_i) |=> w_valid);

endmodule

// File: tb/tb_per2axi_req_pipe.sv
// Directed testbench for per2axi_req_pipe with a 128-bit data path and a
// credit limit of 2 per direction.

module tb_per2axi_req_pipe;

  localparam int PAW = 32;
  localparam int PIW = 5;
  localparam int AAW = 32;
  localparam int ADW = 128;
  localparam int AIW = 3;
  localparam int AUW = 6;
  localparam int MAXO = 2;
  localparam int CW = $clog2(MAXO + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic           req, gnt, we;
  logic [PAW-1:0] add;
  logic [5:0]     atop;
  logic [31:0]    wdata;
  logic [3:0]     be;
  logic [PIW-1:0] id;

  logic           aw_valid, aw_lock, aw_ready;
  logic [AAW-1:0] aw_addr;
  logic [2:0]     aw_size, aw_prot, ar_prot;
  logic [5:0]     aw_atop;
  logic [AIW-1:0] aw_id, ar_id;
  logic [3:0]     aw_region, aw_cache, aw_qos, ar_region, ar_cache, ar_qos;
  logic [7:0]     aw_len, ar_len;
  logic [AUW-1:0] aw_user, ar_user, w_user;
  logic [1:0]     aw_burst, ar_burst;
  logic           ar_valid, ar_lock, ar_ready;
  logic [AAW-1:0] ar_addr;
  logic [2:0]     ar_size;
  logic           w_valid, w_last, w_ready;
  logic [ADW-1:0] w_data;
  logic [ADW/8-1:0] w_strb;
  logic           b_done, r_done;
  logic           trans_req, atop_req;
  logic [AIW-1:0] trans_id, atop_id;
  logic [AAW-1:0] trans_add, atop_add;
  logic [1:0]     dbg_state;
  logic [CW-1:0]  wr_cnt, rd_cnt;

  per2axi_req_pipe #(
    .PER_ADDR_WIDTH(PAW), .PER_ID_WIDTH(PIW), .AXI_ADDR_WIDTH(AAW),
    .AXI_DATA_WIDTH(ADW), .AXI_ID_WIDTH(AIW), .AXI_USER_WIDTH(AUW),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .per_slave_req_i(req), .per_slave_gnt_o(gnt), .per_slave_add_i(add),
    .per_slave_we_i(we), .per_slave_atop_i(atop), .per_slave_wdata_i(wdata),
    .per_slave_be_i(be), .per_slave_id_i(id),
    .axi_master_aw_valid_o(aw_valid), .axi_master_aw_addr_o(aw_addr),
    .axi_master_aw_size_o(aw_size), .axi_master_aw_lock_o(aw_lock),
    .axi_master_aw_atop_o(aw_atop), .axi_master_aw_id_o(aw_id),
    .axi_master_aw_ready_i(aw_ready), .axi_master_aw_prot_o(aw_prot),
    .axi_master_aw_region_o(aw_region), .axi_master_aw_len_o(aw_len),
    .axi_master_aw_cache_o(aw_cache), .axi_master_aw_qos_o(aw_qos),
    .axi_master_aw_user_o(aw_user), .axi_master_aw_burst_o(aw_burst),
    .axi_master_ar_valid_o(ar_valid), .axi_master_ar_addr_o(ar_addr),
    .axi_master_ar_size_o(ar_size), .axi_master_ar_lock_o(ar_lock),
    .axi_master_ar_id_o(ar_id), .axi_master_ar_ready_i(ar_ready),
    .axi_master_ar_prot_o(ar_prot), .axi_master_ar_region_o(ar_region),
    .axi_master_ar_len_o(ar_len), .axi_master_ar_cache_o(ar_cache),
    .axi_master_ar_qos_o(ar_qos), .axi_master_ar_user_o(ar_user),
    .axi_master_ar_burst_o(ar_burst),
    .axi_master_w_valid_o(w_valid), .axi_master_w_data_o(w_data),
    .axi_master_w_strb_o(w_strb), .axi_master_w_last_o(w_last),
    .axi_master_w_user_o(w_user), .axi_master_w_ready_i(w_ready),
    .b_done_i(b_done), .r_done_i(r_done),
    .trans_req_o(trans_req), .trans_id_o(trans_id), .trans_add_o(trans_add),
    .atop_req_o(atop_req), .atop_id_o(atop_id), .atop_add_o(atop_add),
    .dbg_state_o(dbg_state), .dbg_wr_cnt_o(wr_cnt), .dbg_rd_cnt_o(rd_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [127:0] obs,
                          input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    req = 1'b0; we = 1'b0; add = '0; atop = '0; wdata = '0; be = '0; id = '0;
    aw_ready = 1'b0; ar_ready = 1'b0; w_ready = 1'b0;
    b_done = 1'b0; r_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic w_e,
                           input logic [5:0] at, input logic [31:0] d,
                           input logic [3:0] b, input logic [4:0] i);
    req = 1'b1; add = a; we = w_e; atop = at; wdata = d; be = b; id = i;
  endtask

  // ---------------- stimulus ----------------
  int aw_hs_cnt, w_hs_cnt;
  logic [31:0] a_exp;

  initial begin
    clear_inputs();
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ar_valid", ar_valid, 1'b0);
    check_eq("rst_aw_valid", aw_valid, 1'b0);
    check_eq("rst_w_valid", w_valid, 1'b0);
    check_eq("rst_state", dbg_state, 2'd0);
    check_eq("rst_cnts", {wr_cnt, rd_cnt}, '0);
    check_eq("rst_pulses", {trans_req, atop_req, gnt}, 3'b000);
    check_eq("tieoffs", {aw_prot, aw_region, aw_len, aw_cache, aw_qos, aw_user,
                         aw_burst, ar_prot, ar_region, ar_len, ar_cache, ar_qos,
                         ar_user, ar_burst, w_user}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- Read at 0x1004, held off by ar_ready for 3 cycles ----
    @(negedge clk);
    drive_req(32'h1004, 1'b1, 6'd0, 32'h0, 4'hF, 5'b00100);
    #1 check_eq("rd_gnt", gnt, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req = 1'b0;
      #1;
      check_eq("rd_ar_valid", ar_valid, 1'b1);
      check_eq("rd_ar_addr", ar_addr, 32'h1004);
      check_eq("rd_ar_id", ar_id, 3'd2);
      check_eq("rd_ar_size", ar_size, 3'd2);
      check_eq("rd_trans_idle", trans_req, 1'b0);
    end
    @(negedge clk);
    ar_ready = 1'b1;
    #1;
    check_eq("rd_trans_req", trans_req, 1'b1);
    check_eq("rd_trans_id", trans_id, 3'd2);
    check_eq("rd_trans_add", trans_add, 32'h1004);
    @(negedge clk);
    ar_ready = 1'b0;
    #1;
    check_eq("rd_done_valid", ar_valid, 1'b0);
    check_eq("rd_trans_once", trans_req, 1'b0);
    check_eq("rd_cnt_one", rd_cnt, 2'd1);

    // ---- Write at 0x2006, AW and W complete in different cycles ----
    do_reset();
    @(negedge clk);
    drive_req(32'h2006, 1'b0, 6'd0, 32'hAABB_0000, 4'b1100, 5'b00001);
    #1 check_eq("wr_gnt", gnt, 1'b1);
    @(negedge clk);
    req = 1'b0; aw_ready = 1'b1; w_ready = 1'b0;
    #1;
    check_eq("wr_aw_valid", aw_valid, 1'b1);
    check_eq("wr_w_valid", w_valid, 1'b1);
    check_eq("wr_aw_addr", aw_addr, 32'h2006);
    check_eq("wr_strb", w_strb, 16'h00C0);
    check_eq("wr_data", w_data, 128'h00000000_00000000_AABB0000_00000000);
    check_eq("wr_size", aw_size, 3'd1);
    check_eq("wr_last", w_last, 1'b1);
    @(negedge clk);
    aw_ready = 1'b0;
    drive_req(32'h40, 1'b1, 6'd0, 32'h0, 4'hF, 5'b00010);
    #1;
    check_eq("wr_aw_gone", aw_valid, 1'b0);
    check_eq("wr_w_wait", w_valid, 1'b1);
    check_eq("wr_busy_gnt", gnt, 1'b0);
    @(negedge clk);
    w_ready = 1'b1;
    #1 check_eq("wr_free_gnt", gnt, 1'b1);
    @(negedge clk);
    req = 1'b0; w_ready = 1'b0;
    #1;
    check_eq("wr_next_state", dbg_state, 2'd1);
    check_eq("wr_next_ar_addr", ar_addr, 32'h40);
    check_eq("wr_w_done", w_valid, 1'b0);
    check_eq("wr_cnts", {wr_cnt, rd_cnt}, {2'd1, 2'd1});

    // ---- AMO AND: inverted data, CLR atop, both credits ----
    do_reset();
    @(negedge clk);
    drive_req(32'h3000, 1'b0, 6'b101100, 32'h0000_00FF, 4'hF, 5'b10000);
    #1 check_eq("amo_gnt", gnt, 1'b1);
    @(negedge clk);
    req = 1'b0; aw_ready = 1'b1; w_ready = 1'b1;
    #1;
    check_eq("amo_atop", aw_atop, 6'b100001);
    check_eq("amo_wdata", w_data[31:0], 32'hFFFF_FF00);
    check_eq("amo_aw_id", aw_id, 3'd4);
    check_eq("amo_atop_req", atop_req, 1'b1);
    check_eq("amo_atop_info", {atop_id, atop_add}, {3'd4, 32'h3000});
    check_eq("amo_no_trans", trans_req, 1'b0);
    check_eq("amo_cnts", {wr_cnt, rd_cnt}, {2'd1, 2'd1});
    @(negedge clk);
    aw_ready = 1'b0; w_ready = 1'b0;
    #1;
    check_eq("amo_pulse_end", atop_req, 1'b0);
    check_eq("amo_state", dbg_state, 2'd0);

    // ---- LR goes out as a locked read, SC as a locked plain write ----
    do_reset();
    @(negedge clk);
    drive_req(32'h60, 1'b0, 6'b100010, 32'h0, 4'hF, 5'b00001);
    #1 check_eq("lr_gnt", gnt, 1'b1);
    @(negedge clk);
    ar_ready = 1'b1;
    drive_req(32'h64, 1'b0, 6'b100011, 32'h1234_5678, 4'hF, 5'b00001);
    #1;
    check_eq("lr_ar", {ar_valid, ar_lock, aw_valid}, 3'b110);
    check_eq("sc_gnt", gnt, 1'b1);
    @(negedge clk);
    req = 1'b0; ar_ready = 1'b0; aw_ready = 1'b1; w_ready = 1'b1;
    #1;
    check_eq("sc_aw", {aw_valid, aw_lock, aw_atop}, {2'b11, 6'd0});
    check_eq("sc_no_atop_req", atop_req, 1'b0);
    check_eq("sc_cnts", {wr_cnt, rd_cnt}, {2'd1, 2'd1});

    // ---- Read credit limit (2) and same-cycle credit return ----
    do_reset();
    @(negedge clk);
    drive_req(32'h100, 1'b1, 6'd0, 32'h0, 4'hF, 5'b00001);
    #1 check_eq("cr_gnt0", gnt, 1'b1);
    @(negedge clk);
    ar_ready = 1'b1;
    drive_req(32'h104, 1'b1, 6'd0, 32'h0, 4'hF, 5'b00001);
    #1 check_eq("cr_gnt1", gnt, 1'b1);
    @(negedge clk);
    drive_req(32'h108, 1'b1, 6'd0, 32'h0, 4'hF, 5'b00001);
    #1 check_eq("cr_gnt2_blocked", gnt, 1'b0);
    #1 r_done = 1'b1;
    #1 check_eq("cr_gnt2_returned", gnt, 1'b1);
    @(negedge clk);
    req = 1'b0; r_done = 1'b0; ar_ready = 1'b0;
    #1;
    check_eq("cr_cnt_stays", rd_cnt, 2'd2);
    check_eq("cr_third_addr", ar_addr, 32'h108);

    // ---- Back-to-back writes, all readies high, lanes rotate ----
    do_reset();
    aw_ready = 1'b1; w_ready = 1'b1;
    aw_hs_cnt = 0; w_hs_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      b_done = (k >= 1);
      if (k < 8) drive_req(32'h4000 + 4 * k, 1'b0, 6'd0, 32'h1111_0000 + k, 4'hF, 5'b00001);
      else req = 1'b0;
      #1;
      if (aw_valid && aw_ready) begin
        check_eq("b2b_sb_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          a_exp = exp_q.pop_front();
          check_eq("b2b_aw_addr", aw_addr, a_exp);
          check_eq("b2b_w_strb", w_strb, 16'hF << (4 * a_exp[3:2]));
        end
        aw_hs_cnt++;
      end
      if (w_valid && w_ready) w_hs_cnt++;
      if (k < 8) begin
        check_eq("b2b_gnt", gnt, 1'b1);
        exp_q.push_back(32'h4000 + 4 * k);
      end
    end
    @(negedge clk);
    b_done = 1'b0;
    #1;
    check_eq("b2b_aw_count", aw_hs_cnt, 8);
    check_eq("b2b_w_count", w_hs_cnt, 8);
    check_eq("b2b_sb_drained", exp_q.size(), 0);
    check_eq("b2b_wr_cnt", wr_cnt, 2'd0);
    check_eq("b2b_idle", dbg_state, 2'd0);

    // ---- Reset in the middle of a pending write ----
    do_reset();
    @(negedge clk);
    drive_req(32'h5000, 1'b0, 6'd0, 32'hDEAD_BEEF, 4'hF, 5'b00001);
    @(negedge clk);
    req = 1'b0;
    #1 check_eq("mid_aw_valid", aw_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_aw_drop", aw_valid, 1'b0);
    check_eq("mid_w_drop", w_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_eq("mid_cnts", {wr_cnt, rd_cnt}, '0);
    check_eq("mid_state", dbg_state, 2'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
